ctrl_tx: RTL and testbench
==========================

Name: ctrl_tx

Overview:
- AXI4-Lite write-side master that pushes user bytes into the UART-Lite TX FIFO.
- Per accepted byte:
  - polls the UART status register over the read channel until TX FIFO not full;
  - then writes the byte to the TX FIFO register over the AW/W/B channels.
- Sits beside ctrl_rx on the same UART AXI4-Lite slave port; the interconnect/arbiter merges the two read channels.

Parameters:
- STAT_ADDR, 4'd8, status register address.
- TX_ADDR, 4'd4, TX FIFO write address.
- TX_FULL_BIT, 3, rdata bit index meaning TX FIFO full.
- POLL_GAP, 4, idle cycles between a "full" status read and the next poll (0 = re-poll immediately); counter width 8 bits, POLL_GAP ≤ 255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  8  byte to transmit.
- data_valid  in  1  data_in valid.
- data_ready  out  1  block can accept a byte.
- tx_done  out  1  one-cycle pulse: byte write completed (B handshake).
- tx_err  out  1  last write returned bresp != OKAY; held until next completion.
- araddr  out  4  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read data.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- awaddr  out  4  write address, constant TX_ADDR.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  32  {24'd0, byte_q}.
- wstrb  out  4  constant 4'b0001.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bresp  in  2  write response.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Behaviour:
- Reset (async, active-high): state=IDLE, byte_q=0, aw_done=w_done=0, gap counter=0, tx_done=0, tx_err=0.
  - All valid/ready outputs are decoded from state, so they drop immediately on reset assertion, including mid-transaction.
  - Reset is the only abort path.
- States:
  - IDLE: data_ready=1. On data_valid: byte_q<=data_in, -> AR.
  - AR: arvalid=1, araddr=STAT_ADDR. Hold until arready, then -> R.
  - R: rready=1. On rvalid:
    - rdata[TX_FULL_BIT]=1 and POLL_GAP>0: load counter=POLL_GAP-1, -> WAIT.
    - rdata[TX_FULL_BIT]=1 and POLL_GAP=0: -> AR.
    - otherwise: -> W.
    - All other rdata bits are ignored.
  - WAIT: decrement counter; at 0, -> AR. No bus activity.
  - W: awvalid=~aw_done, wvalid=~w_done.
    - awvalid&awready sets aw_done; wvalid&wready sets w_done.
    - Leave for B when both are complete, counting completions in the current cycle (same-cycle or either order).
    - Clear both flags on exit.
  - B: bready=1. On bvalid: tx_err<=(bresp!=2'b00), tx_done<=1 for the next cycle only, -> IDLE.
- Outside AR, araddr=0. Outside R/W/B, rready/awvalid/wvalid/bready=0.
- Valids, once raised, are never withdrawn before their handshake except by reset.
- byte_q is stable from acceptance until the B handshake. data_valid is ignored outside IDLE.
- Latency, all slave readies high and one-cycle responses:
  - accept at edge 0; arvalid at cycle 1; rready cycle 2; aw/wvalid cycle 3; bready cycle 4;
  - IDLE with data_ready=1 and tx_done=1 at cycle 5.
  - Throughput: 1 byte per 5 cycles best case.
- Each "full" poll adds 2 + POLL_GAP cycles minimum.

Test Plan:
- Reset mid-W with awvalid=1 → awvalid/wvalid low same cycle; data_ready=1 after release; tx_err=0.
- Byte 0xA5, slave always ready, rdata=0 → araddr=8 accepted, then awaddr=4, wdata=0x000000A5, wstrb=0001; tx_done pulses exactly 1 cycle at cycle 5; tx_err=0.
- Status reads return rdata=0x08 twice, then 0x00; POLL_GAP=4 → three AR handshakes at araddr=8, ≥4 idle cycles between polls, single write of byte.
- awready delayed 3 cycles while wready immediate (and reverse; and both same cycle) → exactly one AW and one W handshake each, then bready.
- bresp=2'b10 → tx_err=1 after completion. Next byte with bresp=00 → tx_err=0.
- data_valid held high with bytes 0x01, 0x02 → both written in order. data_in changes while busy do not alter wdata.

Source files
------------

// File: rtl/ctrl_tx.sv
// ctrl_tx: AXI4-Lite master that polls UART-Lite status and writes user bytes into its TX FIFO.
module ctrl_tx #(
  parameter logic [3:0] STAT_ADDR   = 4'd8,
  parameter logic [3:0] TX_ADDR     = 4'd4,
  parameter int         TX_FULL_BIT = 3,
  parameter int         POLL_GAP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        tx_done,
  output logic        tx_err,
  output logic [3:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, AR, R, WAIT, W, B} state_t;
  localparam logic [7:0] GAP_LD = POLL_GAP == 0 ? 8'd0 : 8'(POLL_GAP - 1);
  state_t     state;
  logic [7:0] byte_q;
  logic [7:0] gap_cnt;
  logic       aw_done;
  logic       w_done;
  logic       aw_fin;
  logic       w_fin;
  logic       unused_rdata;
  // Bus strobes decode straight from state so reset drops them immediately.
  assign data_ready   = state == IDLE;
  assign arvalid      = state == AR;
  assign araddr       = arvalid ? STAT_ADDR : 4'd0;
  assign rready       = state == R;
  assign awvalid      = (state == W) & ~aw_done;
  assign wvalid       = (state == W) & ~w_done;
  assign bready       = state == B;
  assign awaddr       = TX_ADDR;
  assign wdata        = {24'd0, byte_q};
  assign wstrb        = 4'b0001;
  assign aw_fin       = aw_done | (awvalid & awready);
  assign w_fin        = w_done | (wvalid & wready);
  assign unused_rdata = ^rdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      byte_q  <= 8'd0;
      gap_cnt <= 8'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (data_valid) begin
          byte_q <= data_in;
          state  <= AR;
        end
        AR: if (arready) state <= R;
        R: if (rvalid) begin
          gap_cnt <= GAP_LD;
          state   <= rdata[TX_FULL_BIT] ? (POLL_GAP == 0 ? AR : WAIT) : W;
        end
        WAIT: if (gap_cnt == 8'd0) state <= AR;
              else gap_cnt <= gap_cnt - 8'd1;
        W: if (aw_fin & w_fin) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          state   <= B;
        end else begin
          aw_done <= aw_fin;
          w_done  <= w_fin;
        end
        B: if (bvalid) begin
          tx_err  <= bresp != 2'b00;
          tx_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: scoreboard bench for ctrl_tx with a reactive AXI4-Lite slave model.
module tb_ctrl_tx;
  localparam int POLL_GAP = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic        data_ready, tx_done, tx_err;
  logic [3:0]  araddr, awaddr, wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [31:0] wdata;
  logic [1:0]  bresp = 2'd0;

  ctrl_tx #(.STAT_ADDR(4'd8), .TX_ADDR(4'd4), .TX_FULL_BIT(3), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .tx_done(tx_done), .tx_err(tx_err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Knobs written only by the stimulus process.
  int          aw_lat = 0;
  int          w_lat = 0;
  logic [1:0]  cur_bresp = 2'd0;
  logic [31:0] stat_arr [4];
  int          stat_len = 0;
  int          stat_gen = 0;
  // State written only by the slave/monitor process.
  int          cyc = 0, n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  int          aw_cnt = 0, w_cnt = 0, gap_from = -1, stat_idx = 0, seen_gen = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  wr_log [$];
  logic [31:0] cur_stat = 32'd0;
  bit          rd_pend, b_pend, aw_got, w_got, done_exp, mod_err, p_ar, p_aw, p_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave responses are decided at negedge, so valid&ready here is exactly the handshake at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      {rd_pend, b_pend, aw_got, w_got, done_exp, mod_err, p_ar, p_aw, p_w} = '0;
      {arready, rvalid, awready, wready, bvalid} = '0;
      rdata = 32'd0;
      bresp = 2'd0;
      aw_cnt = 0;
      w_cnt = 0;
      gap_from = -1;
    end else begin
      chk("data_ready", 32'(data_ready), 32'(exp_q.size() == 0));
      chk("tx_done", 32'(tx_done), 32'(done_exp));
      chk("tx_err", 32'(tx_err), 32'(mod_err));
      chk("araddr", 32'(araddr), arvalid ? 32'd8 : 32'd0);
      if (awvalid) begin
        chk("awaddr", 32'(awaddr), 32'd4);
        chk("aw_once", 32'(aw_got), 32'd0);
      end
      if (wvalid) begin
        chk("wdata", wdata, exp_q.size() != 0 ? {24'd0, exp_q[0]} : 32'hDEAD_BEEF);
        chk("wstrb", 32'(wstrb), 32'd1);
        chk("w_once", 32'(w_got), 32'd0);
      end
      if (p_ar) chk("arvalid_hold", 32'(arvalid), 32'd1);
      if (p_aw) chk("awvalid_hold", 32'(awvalid), 32'd1);
      if (p_w) chk("wvalid_hold", 32'(wvalid), 32'd1);
      if (gap_from >= 0) begin
        if (cyc <= gap_from + POLL_GAP) chk("gap_idle", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        else begin
          chk("gap_repoll", 32'(arvalid), 32'd1);
          gap_from = -1;
        end
      end
      if (seen_gen != stat_gen) begin
        seen_gen = stat_gen;
        stat_idx = 0;
      end
      done_exp = 1'b0;
      arready = arvalid;
      rvalid = rd_pend;
      rdata = rd_pend ? cur_stat : 32'd0;
      awready = awvalid && aw_cnt >= aw_lat;
      wready = wvalid && w_cnt >= w_lat;
      bvalid = b_pend;
      bresp = b_pend ? cur_bresp : 2'd0;
      if (data_valid && data_ready) exp_q.push_back(data_in);
      if (arvalid && arready) begin
        n_ar++;
        rd_pend = 1'b1;
        cur_stat = stat_idx < stat_len ? stat_arr[stat_idx] : 32'd0;
        stat_idx++;
      end
      if (rvalid && rready) begin
        rd_pend = 1'b0;
        if (rdata[3]) gap_from = cyc;
      end
      if (awvalid && awready) begin
        n_aw++;
        aw_got = 1'b1;
        aw_cnt = 0;
      end else if (awvalid) aw_cnt++;
      if (wvalid && wready) begin
        n_w++;
        w_got = 1'b1;
        w_cnt = 0;
      end else if (wvalid) w_cnt++;
      if (bvalid && bready) begin
        n_b++;
        b_pend = 1'b0;
        aw_got = 1'b0;
        w_got = 1'b0;
        done_exp = 1'b1;
        mod_err = cur_bresp != 2'b00;
        if (exp_q.size() != 0) wr_log.push_back(exp_q.pop_front());
      end
      if (aw_got && w_got) b_pend = 1'b1;
      p_ar = arvalid && !arready;
      p_aw = awvalid && !awready;
      p_w = wvalid && !wready;
    end
  end

  task automatic send(input logic [7:0] b, input bit keep);
    int n = 0;
    data_in = b;
    data_valid = 1'b1;
    while (!data_ready && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!data_ready) chk("accept_timeout", 32'(data_ready), 32'd1);
    @(posedge clk);
    #2;
    if (!keep) data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tx_done && n < 400);
    if (!tx_done) chk("done_timeout", 32'(tx_done), 32'd1);
  endtask

  task automatic set_stat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input int len);
    stat_arr[0] = a;
    stat_arr[1] = b;
    stat_arr[2] = c;
    stat_arr[3] = 32'd0;
    stat_len = len;
    stat_gen++;
  endtask

  initial begin
    int k, a0, aw0, w0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_ready", 32'(data_ready), 32'd1);
    chk("rst_strobes", 32'({arvalid, rready, awvalid, wvalid, bready, tx_done, tx_err}), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    // Best-case latency: accept edge, then tx_done visible after the 4th following edge.
    send(8'hA5, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!tx_done && k < 20);
    chk("latency_edges", 32'(k), 32'd4);
    chk("a5_logged", 32'(wr_log[wr_log.size()-1]), 32'hA5);
    chk("a5_err", 32'(tx_err), 32'd0);
    @(posedge clk);
    #1;
    chk("tx_done_pulse", 32'(tx_done), 32'd0);
    #1;
    // Two "full" status reads then not-full.
    set_stat(32'h08, 32'h08, 32'h00, 3);
    a0 = n_ar;
    w0 = n_w;
    send(8'h3C, 1'b0);
    wait_done();
    chk("poll_ar_count", 32'(n_ar - a0), 32'd3);
    chk("poll_w_count", 32'(n_w - w0), 32'd1);
    // Every bit except the full flag set: still treated as not full.
    set_stat(32'hFFFF_FFF7, 32'h0, 32'h0, 1);
    a0 = n_ar;
    #1 send(8'h5A, 1'b0);
    wait_done();
    chk("ignore_bits_ar", 32'(n_ar - a0), 32'd1);
    // AW/W skew in both orders and same cycle.
    for (int i = 0; i < 3; i++) begin
      aw_lat = i == 0 ? 3 : (i == 1 ? 0 : 2);
      w_lat = i == 0 ? 0 : (i == 1 ? 3 : 2);
      aw0 = n_aw;
      w0 = n_w;
      #1 send(8'h10 + 8'(i), 1'b0);
      wait_done();
      chk("skew_aw_count", 32'(n_aw - aw0), 32'd1);
      chk("skew_w_count", 32'(n_w - w0), 32'd1);
      chk("skew_byte", 32'(wr_log[wr_log.size()-1]), 32'h10 + 32'(i));
    end
    aw_lat = 0;
    w_lat = 0;
    // Error response sets tx_err, next OKAY clears it.
    cur_bresp = 2'b10;
    #1 send(8'h77, 1'b0);
    wait_done();
    chk("slverr_set", 32'(tx_err), 32'd1);
    cur_bresp = 2'b00;
    #1 send(8'h78, 1'b0);
    wait_done();
    chk("okay_clear", 32'(tx_err), 32'd0);
    // Held data_valid: two bytes in order, data_in churn while busy.
    #1 send(8'h01, 1'b1);
    data_in = 8'hEE;
    repeat (2) @(posedge clk);
    #2 send(8'h02, 1'b0);
    wait_done();
    chk("b2b_first", 32'(wr_log[wr_log.size()-2]), 32'h01);
    chk("b2b_second", 32'(wr_log[wr_log.size()-1]), 32'h02);
    // Reset mid-W with tx_err previously set.
    cur_bresp = 2'b10;
    #1 send(8'h99, 1'b0);
    wait_done();
    chk("pre_rst_err", 32'(tx_err), 32'd1);
    cur_bresp = 2'b00;
    aw_lat = 6;
    #1 send(8'h42, 1'b0);
    n = 0;
    while (!awvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_rst_awvalid", 32'(awvalid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_aw_w_low", 32'({awvalid, wvalid}), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(data_ready), 32'd1);
    chk("post_rst_err", 32'(tx_err), 32'd0);
    aw_lat = 0;
    send(8'h5F, 1'b0);
    wait_done();
    chk("post_rst_byte", 32'(wr_log[wr_log.size()-1]), 32'h5F);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
